// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_VALID = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
    localparam logic [1:0] PC_SEL_BR   = 2'b01;
    localparam logic [1:0] PC_SEL_JALR = 2'b10;
    localparam logic [1:0] PC_SEL_JAL  = 2'b11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, branch, jalr, jal, plus alignment check.
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pc_sel,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] jalr_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] rel_pc;

    // Both sums wrap modulo 2^XLEN by construction.
    assign seq_pc = pc + XLEN'(4);
    assign rel_pc = pc + imm;

    always_comb begin
        next_pc = seq_pc;
        case (pc_sel)
            PC_SEL_SEQ:  next_pc = seq_pc;
            PC_SEL_BR:   next_pc = branch_taken ? rel_pc : seq_pc;
            PC_SEL_JALR: next_pc = jalr_target & ~XLEN'(1);
            PC_SEL_JAL:  next_pc = rel_pc;
            default:     next_pc = seq_pc;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/gnt/rvalid, holds instr for the decoder.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic [1:0]      pc_sel,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] jalr_target,
    output logic            misalign_err,
    output logic [2:0]      fsm_state
);

    // Handshakes: a fetch is accepted on a cycle with imem_req && imem_gnt; data is taken
    // on imem_rvalid only while waiting; an instruction retires on instr_valid && instr_ready.

    state_t          state;
    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;

    assign fsm_state = state;

    next_pc_calc #(.XLEN(XLEN)) u_next_pc (
        .pc           (instr_pc),
        .pc_sel       (pc_sel),
        .branch_taken (branch_taken),
        .imm          (imm),
        .jalr_target  (jalr_target),
        .next_pc      (next_pc),
        .misaligned   (next_misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            instr_valid  <= 1'b0;
            instr        <= NOP_INSTR;
            instr_pc     <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    imem_req  <= 1'b1;
                    imem_addr <= RESET_PC;
                    state     <= ST_REQ;
                end
                ST_REQ: begin
                    if (imem_gnt) begin
                        imem_req <= 1'b0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_pc    <= imem_addr;
                        instr_valid <= 1'b1;
                        state       <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (next_misaligned) begin
                            misalign_err <= 1'b1;
                            state        <= ST_HALT;
                        end else begin
                            imem_addr <= next_pc;
                            imem_req  <= 1'b1;
                            state     <= ST_REQ;
                        end
                    end
                end
                ST_HALT: begin
                    // Sticky until reset.
                    imem_req     <= 1'b0;
                    instr_valid  <= 1'b0;
                    misalign_err <= 1'b1;
                end
                default: begin
                    state    <= ST_HALT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard on fetch addresses and retired instructions.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic [1:0]  pc_sel = 2'b11;
    logic        branch_taken = 1'b1;
    logic [31:0] imm = 32'h2;
    logic [31:0] jalr_target = 32'h3;
    logic        misalign_err;
    logic [2:0]  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] addr_q[$];
    logic [63:0] instr_q[$];

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .pc_sel       (pc_sel),
        .branch_taken (branch_taken),
        .imm          (imm),
        .jalr_target  (jalr_target),
        .misalign_err (misalign_err),
        .fsm_state    (fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},      64'(imem_req),     64'(0));
        check({tag, "_addr"},     64'(imem_addr),    64'(32'h0));
        check({tag, "_valid"},    64'(instr_valid),  64'(0));
        check({tag, "_instr"},    64'(instr),        64'(NOP_INSTR));
        check({tag, "_pc"},       64'(instr_pc),     64'(32'h0));
        check({tag, "_misalign"}, 64'(misalign_err), 64'(0));
        check({tag, "_state"},    64'(fsm_state),    64'(ST_IDLE));
    endtask

    // driver: answer one fetch, gnt after gnt_delay cycles; a stray rvalid is sent during REQ
    task automatic serve(input int gnt_delay, input logic [31:0] data, input logic [31:0] exp_addr);
        int t = 0;
        while (!imem_req && t < 20) begin
            @(posedge clk); #1; t++;
        end
        check("req_seen", 64'(imem_req), 64'(1));
        addr_q.push_back(exp_addr);
        instr_q.push_back({exp_addr, data});
        for (int i = 0; i < gnt_delay; i++) begin
            imem_rvalid = (i == 0);
            imem_rdata  = 32'hDEAD_BEEF;
            @(posedge clk); #1;
            imem_rvalid = 1'b0;
            check("req_hold",  64'(imem_req),  64'(1));
            check("addr_hold", 64'(imem_addr), 64'(exp_addr));
            check("state_req", 64'(fsm_state), 64'(ST_REQ));
        end
        imem_gnt = 1'b1;
        @(posedge clk); #1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
    endtask

    // driver: retire the current instruction; decoder inputs are junk outside this cycle
    task automatic retire(input logic [1:0] sel, input logic taken, input logic [31:0] off,
                          input logic [31:0] jt, output time t_retire);
        int t = 0;
        while (!instr_valid && t < 20) begin
            @(posedge clk); #1; t++;
        end
        check("valid_seen", 64'(instr_valid), 64'(1));
        pc_sel       = sel;
        branch_taken = taken;
        imm          = off;
        jalr_target  = jt;
        instr_ready  = 1'b1;
        @(posedge clk);
        t_retire = $time;
        #1;
        instr_ready  = 1'b0;
        pc_sel       = 2'b11;
        branch_taken = 1'b1;
        imm          = 32'h2;
        jalr_target  = 32'h3;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req && imem_gnt) begin
                if (addr_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL fetch_addr: unexpected fetch of %h", imem_addr);
                end else begin
                    check("fetch_addr", 64'(imem_addr), 64'(addr_q.pop_front()));
                end
            end
            if (instr_valid && instr_ready) begin
                if (instr_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL retire: unexpected retire pc %h instr %h", instr_pc, instr);
                end else begin
                    check("retire_pc_instr", {instr_pc, instr}, instr_q.pop_front());
                end
            end
        end
    end

    initial begin
        time t0, t1, t2, tx;
        logic saw_req;

        #1 rst_n = 1'b0;
        #2 check_reset_values("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // back-to-back sequential fetches, best-case cadence
        serve(0, 32'h1111_0001, 32'h0);  retire(PC_SEL_SEQ, 1'b0, 32'h0, 32'h0, t0);
        serve(0, 32'h1111_0002, 32'h4);  retire(PC_SEL_SEQ, 1'b0, 32'h0, 32'h0, t1);
        serve(0, 32'h1111_0003, 32'h8);  retire(PC_SEL_SEQ, 1'b0, 32'h0, 32'h0, t2);
        check("cadence_1", 64'(t1 - t0), 64'(30));
        check("cadence_2", 64'(t2 - t1), 64'(30));

        // delayed grant with stray rvalid, then a 5-cycle stall in VALID
        serve(3, 32'h2222_000C, 32'hC);
        for (int i = 0; i < 5; i++) begin
            imem_rvalid = (i == 0);
            imem_rdata  = 32'hBAD0_BAD0;
            @(posedge clk); #1;
            imem_rvalid = 1'b0;
            check("stall_instr", 64'(instr),       64'(32'h2222_000C));
            check("stall_pc",    64'(instr_pc),    64'(32'hC));
            check("stall_valid", 64'(instr_valid), 64'(1));
            check("stall_noreq", 64'(imem_req),    64'(0));
        end
        retire(PC_SEL_SEQ, 1'b0, 32'h0, 32'h0, tx);

        // branches, wrap, jalr
        serve(0, 32'h3333_0010, 32'h10);        retire(PC_SEL_JAL, 1'b0, 32'hF0, 32'h0, tx);
        serve(0, 32'h3333_0100, 32'h100);       retire(PC_SEL_BR, 1'b1, 32'hFFFF_FFF8, 32'h0, tx);
        serve(0, 32'h3333_00F8, 32'hF8);        retire(PC_SEL_JAL, 1'b0, 32'h8, 32'h0, tx);
        serve(0, 32'h3333_0101, 32'h100);       retire(PC_SEL_BR, 1'b0, 32'hFFFF_FFF8, 32'h0, tx);
        serve(0, 32'h3333_0104, 32'h104);       retire(PC_SEL_JAL, 1'b0, 32'hFFFF_FEF8, 32'h0, tx);
        serve(0, 32'h3333_FFFC, 32'hFFFF_FFFC); retire(PC_SEL_SEQ, 1'b0, 32'h0, 32'h0, tx);
        serve(0, 32'h3333_0000, 32'h0);         retire(PC_SEL_JALR, 1'b0, 32'h0, 32'h201, tx);
        serve(0, 32'h3333_0200, 32'h200);       retire(PC_SEL_JAL, 1'b0, 32'h2, 32'h0, tx);

        // misaligned target: halt
        check("halt_misalign", 64'(misalign_err), 64'(1));
        check("halt_state",    64'(fsm_state),    64'(ST_HALT));
        check("halt_valid",    64'(instr_valid),  64'(0));
        saw_req = imem_req;
        for (int i = 0; i < 8; i++) begin
            instr_ready = 1'b1;
            imem_gnt    = 1'b1;
            @(posedge clk); #1;
            saw_req = saw_req | imem_req;
        end
        instr_ready = 1'b0;
        imem_gnt    = 1'b0;
        check("halt_no_req",   64'(saw_req),      64'(0));
        check("halt_sticky",   64'(misalign_err), 64'(1));

        // reset out of HALT, then reset while a fetch is outstanding
        #3 rst_n = 1'b0;
        #1 check_reset_values("rst_halt");
        @(negedge clk) rst_n = 1'b1;
        begin
            int t = 0;
            while (!imem_req && t < 20) begin
                @(posedge clk); #1; t++;
            end
        end
        check("req_after_rst", 64'(imem_req), 64'(1));
        addr_q.push_back(32'h0);
        imem_gnt = 1'b1;
        @(posedge clk); #1;
        imem_gnt = 1'b0;
        check("in_wait", 64'(fsm_state), 64'(ST_WAIT));
        #3 rst_n = 1'b0;
        #1 check_reset_values("rst_wait");
        #2 rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD1_BAD1;
        @(posedge clk); #1;
        check("late_rvalid_1", 64'(instr_valid), 64'(0));
        @(posedge clk); #1;
        check("late_rvalid_2", 64'(instr_valid), 64'(0));
        check("late_state",    64'(fsm_state),   64'(ST_REQ));
        imem_rvalid = 1'b0;
        serve(0, 32'h4444_0000, 32'h0);
        retire(PC_SEL_SEQ, 1'b0, 32'h0, 32'h0, tx);
        @(posedge clk); #1;

        check("addr_q_empty",  64'(addr_q.size()),  64'(0));
        check("instr_q_empty", 64'(instr_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
